data_fetch_unit: RTL and testbench

//  Memory-side responder for the control unit's load/store handshake (ADDR_START/FETCH_DONE, WRADDR_START/STORE_DONE).

---
 rtl/data_fetch_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_data_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_fetch_unit                                               |
// | Purpose  : Memory-side responder for the control unit load/store          |
// |            handshake. A load streams tile words from a sync-read SRAM    |
// |            onto the per-PE DATAIN lanes. A store writes the captured PE  |
// |            DATAOUT lanes sequentially into the SRAM store region.        |
// | Ports    : CLK/RST             clock, synchronous active-high reset       |
// |            ADDR_START/ADDR_RST load request pulse / abort + ptr reset    |
// |            ADDRESS/DIMEN       tile index, words per lane minus one      |
// |            PE_SEL/_2x2/_4      lane mask select                          |
// |            WRADDR_START        store request pulse                       |
// |            FETCH_DONE/STORE_DONE  completion pulses                      |
// |            DATAIN/LANE_VALID   registered lane data and strobes          |
// |            DATAOUT             PE results, captured at store start       |
// |            MEM_RD_*/MEM_WR_*   SRAM read (1-cycle latency) / write ports |
// |            BUSY                high outside IDLE                         |
// | Options  : DATA_FETCH_ERR_EN adds START_ERR, a 1-cycle pulse after a     |
// |            start that was ignored (busy) or dropped (store vs load).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module data_fetch_unit #(
  parameter int                    DATA_W     = 32,
  parameter int                    LANES      = 4,
  parameter int                    MEM_ADDR_W = 8,
  parameter logic [MEM_ADDR_W-1:0] STORE_BASE = 8'hC0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ADDR_START,
  input  logic                    ADDR_RST,
  input  logic [3:0]              ADDRESS,
  input  logic [1:0]              DIMEN,
  input  logic [1:0]              PE_SEL,
  input  logic                    PE_SEL_2x2,
  input  logic                    PE_SEL_4,
  output logic                    FETCH_DONE,
  input  logic                    WRADDR_START,
  output logic                    STORE_DONE,
  output logic [LANES*DATA_W-1:0] DATAIN,
  output logic [LANES-1:0]        LANE_VALID,
  input  logic [LANES*DATA_W-1:0] DATAOUT,
  output logic                    MEM_RD_EN,
  output logic [MEM_ADDR_W-1:0]   MEM_RD_ADDR,
  input  logic [DATA_W-1:0]       MEM_RD_DATA,
  output logic                    MEM_WR_EN,
  output logic [MEM_ADDR_W-1:0]   MEM_WR_ADDR,
  output logic [DATA_W-1:0]       MEM_WR_DATA,
  output logic                    BUSY
`ifdef DATA_FETCH_ERR_EN
  ,
  output logic                    START_ERR
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LDRAIN = 3'd2,
    S_LDONE  = 3'd3,
    S_STORE  = 3'd4,
    S_SDONE  = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [1:0]              dimen_q, dimen_d;
  logic [3:0]              address_q, address_d;
  logic [1:0]              lane_q, lane_d;
  logic [1:0]              k_q, k_d;
  logic [MEM_ADDR_W-1:0]   ptr_q, ptr_d;
  logic [LANES*DATA_W-1:0] dout_q, dout_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [1:0]              rd_lane_q, rd_lane_d;
  logic [LANES*DATA_W-1:0] datain_q, datain_d;
  logic [LANES-1:0]        lane_valid_q, lane_valid_d;

  logic                    rd_en, wr_en;
  logic [LANES-1:0]        mask_in;
  logic                    nxt_found;
  logic [1:0]              nxt_lane;
  logic [MEM_ADDR_W-1:0]   rd_addr;

  function automatic logic [1:0] first_lane(input logic [LANES-1:0] m);
    first_lane = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) first_lane = 2'(i);
    end
  endfunction

  // Lane mask decode from the live select inputs; latched only on a start.
  always_comb begin
    mask_in = '0;
    if (PE_SEL_4)        mask_in = '1;
    else if (PE_SEL_2x2) mask_in = PE_SEL[1] ? LANES'(4'b1100) : LANES'(4'b0011);
    else                 mask_in[PE_SEL] = 1'b1;
  end

  // Next selected lane strictly above the current one.
  always_comb begin
    nxt_found = 1'b0;
    nxt_lane  = lane_q;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(lane_q))) begin
        nxt_found = 1'b1;
        nxt_lane  = 2'(i);
      end
    end
  end

  // Each lane owns a 4-word slot of the 16-word tile, so no carry out.
  assign rd_addr = MEM_ADDR_W'({address_q, 4'h0}) + MEM_ADDR_W'({lane_q, 2'b00})
                 + MEM_ADDR_W'(k_q);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    dimen_d   = dimen_q;
    address_d = address_q;
    lane_d    = lane_q;
    k_d       = k_q;
    ptr_d     = ptr_q;
    dout_d    = dout_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Load has priority; a simultaneous store request is dropped.
        if (ADDR_START) begin
          state_d   = S_LOAD;
          mask_d    = mask_in;
          dimen_d   = DIMEN;
          address_d = ADDRESS;
          lane_d    = first_lane(mask_in);
          k_d       = 2'd0;
        end else if (WRADDR_START) begin
          state_d = S_STORE;
          mask_d  = mask_in;
          dout_d  = DATAOUT;
          lane_d  = first_lane(mask_in);
        end
      end
      S_LOAD: begin
        rd_en = 1'b1;
        if (k_q == dimen_q) begin
          k_d = 2'd0;
          if (nxt_found) lane_d  = nxt_lane;
          else           state_d = S_LDRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      // Wait until the last read has returned and been registered out.
      S_LDRAIN: if (!rd_vld_q) state_d = S_LDONE;
      S_LDONE:  state_d = S_IDLE;
      S_STORE: begin
        wr_en = 1'b1;
        ptr_d = (ptr_q == {MEM_ADDR_W{1'b1}}) ? STORE_BASE : ptr_q + 1'b1;
        if (nxt_found) lane_d  = nxt_lane;
        else           state_d = S_SDONE;
      end
      S_SDONE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Read-return pipeline: data for a read issued last cycle is on MEM_RD_DATA now.
    rd_vld_d     = rd_en;
    rd_lane_d    = lane_q;
    lane_valid_d = '0;
    datain_d     = datain_q;
    if (rd_vld_q) begin
      datain_d[rd_lane_q*DATA_W +: DATA_W] = MEM_RD_DATA;
      lane_valid_d[rd_lane_q]              = 1'b1;
    end

    // Abort overrides everything, including a same-cycle start and in-flight data.
    if (ADDR_RST) begin
      state_d      = S_IDLE;
      ptr_d        = STORE_BASE;
      rd_en        = 1'b0;
      wr_en        = 1'b0;
      rd_vld_d     = 1'b0;
      lane_valid_d = '0;
      datain_d     = datain_q;
    end
  end

`ifdef DATA_FETCH_ERR_EN
  logic start_err_q, start_err_d;
  always_comb begin
    start_err_d = !ADDR_RST &&
                  (((state_q != S_IDLE) && (ADDR_START || WRADDR_START)) ||
                   ((state_q == S_IDLE) && ADDR_START && WRADDR_START));
  end
  assign START_ERR = start_err_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      dimen_q      <= '0;
      address_q    <= '0;
      lane_q       <= '0;
      k_q          <= '0;
      ptr_q        <= STORE_BASE;
      dout_q       <= '0;
      rd_vld_q     <= 1'b0;
      rd_lane_q    <= '0;
      datain_q     <= '0;
      lane_valid_q <= '0;
`ifdef DATA_FETCH_ERR_EN
      start_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      dimen_q      <= dimen_d;
      address_q    <= address_d;
      lane_q       <= lane_d;
      k_q          <= k_d;
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      rd_vld_q     <= rd_vld_d;
      rd_lane_q    <= rd_lane_d;
      datain_q     <= datain_d;
      lane_valid_q <= lane_valid_d;
`ifdef DATA_FETCH_ERR_EN
      start_err_q  <= start_err_d;
`endif
    end
  end

  assign MEM_RD_EN   = rd_en;
  assign MEM_RD_ADDR = rd_en ? rd_addr : '0;
  assign MEM_WR_EN   = wr_en;
  assign MEM_WR_ADDR = wr_en ? ptr_q : '0;
  assign MEM_WR_DATA = wr_en ? dout_q[lane_q*DATA_W +: DATA_W] : '0;
  assign FETCH_DONE  = (state_q == S_LDONE);
  assign STORE_DONE  = (state_q == S_SDONE);
  assign BUSY        = (state_q != S_IDLE);
  assign DATAIN      = datain_q;
  assign LANE_VALID  = lane_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_data_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_fetch_unit                                            |
// | Purpose  : Directed self-checking bench for data_fetch_unit. The SRAM    |
// |            model returns its own address as data (mem[i] = i).           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_data_fetch_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         addr_start = 1'b0, addr_rst = 1'b0, wraddr_start = 1'b0;
  logic [3:0]   address = '0;
  logic [1:0]   dimen = '0, pe_sel = '0;
  logic         pe_sel_2x2 = 1'b0, pe_sel_4 = 1'b0;
  logic         fetch_done, store_done, busy;
  logic [127:0] datain, dataout = '0;
  logic [3:0]   lane_valid;
  logic         mem_rd_en, mem_wr_en;
  logic [7:0]   mem_rd_addr, mem_wr_addr;
  logic [31:0]  mem_rd_data = '0, mem_wr_data;
`ifdef DATA_FETCH_ERR_EN
  logic         start_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] C_A = 32'hAAAA_0001, C_B = 32'hBBBB_0002,
                          C_C = 32'hCCCC_0003, C_D = 32'hDDDD_0004;

  data_fetch_unit dut (
    .CLK(clk), .RST(rst), .ADDR_START(addr_start), .ADDR_RST(addr_rst),
    .ADDRESS(address), .DIMEN(dimen), .PE_SEL(pe_sel), .PE_SEL_2x2(pe_sel_2x2),
    .PE_SEL_4(pe_sel_4), .FETCH_DONE(fetch_done), .WRADDR_START(wraddr_start),
    .STORE_DONE(store_done), .DATAIN(datain), .LANE_VALID(lane_valid),
    .DATAOUT(dataout), .MEM_RD_EN(mem_rd_en), .MEM_RD_ADDR(mem_rd_addr),
    .MEM_RD_DATA(mem_rd_data), .MEM_WR_EN(mem_wr_en), .MEM_WR_ADDR(mem_wr_addr),
    .MEM_WR_DATA(mem_wr_data), .BUSY(busy)
`ifdef DATA_FETCH_ERR_EN
    , .START_ERR(start_err)
`endif
  );

  always #5 clk = ~clk;

  // Sync-read SRAM model holding mem[i] = i.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {24'h0, mem_rd_addr};

  task automatic cfg(input logic [3:0] a, input logic [1:0] d, input logic [1:0] s,
                     input logic s2, input logic s4);
    address = a; dimen = d; pe_sel = s; pe_sel_2x2 = s2; pe_sel_4 = s4;
  endtask

  // Present start request(s) for exactly one rising edge (E0); next negedge is C1.
  task automatic start(input logic ld, input logic st);
    @(negedge clk);
    addr_start = ld; wraddr_start = st;
    @(posedge clk);
    #1;
    addr_start = 1'b0; wraddr_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, fetch_done, store_done, lane_valid, mem_rd_en, mem_wr_en} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {busy, fetch_done, store_done, lane_valid, mem_rd_en, mem_wr_en});
    end
    n_checks++;
    if ({datain, mem_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: datain %h rd_addr %h wr_addr %h wr_data %h required 0", datain, mem_rd_addr, mem_wr_addr, mem_wr_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_full;
    logic [7:0] ea;
    logic [3:0] elv;
    cfg(4'd2, 2'd3, 2'd0, 1'b0, 1'b1);
    start(1'b1, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ea = (c <= 16) ? 8'(8'h20 + c - 1) : 8'h00;
      n_checks++;
      if ({mem_rd_en, mem_rd_addr} !== {(c <= 16), ea}) begin
        n_fail++;
        $display("FAIL load4_read C%0d: en %b addr %h required %b %h", c, mem_rd_en, mem_rd_addr, (c <= 16), ea);
      end
      elv = (c >= 3 && c <= 18) ? 4'(1 << ((c - 3) / 4)) : 4'h0;
      n_checks++;
      if (lane_valid !== elv) begin
        n_fail++;
        $display("FAIL load4_valid C%0d: got %b required %b", c, lane_valid, elv);
      end
      if (c >= 3 && c <= 18) begin
        n_checks++;
        if (datain[((c - 3) / 4) * 32 +: 32] !== 32'(32'h20 + c - 3)) begin
          n_fail++;
          $display("FAIL load4_data C%0d: got %h required %h", c, datain[((c - 3) / 4) * 32 +: 32], 32'h20 + c - 3);
        end
      end
      n_checks++;
      if ({fetch_done, busy} !== {(c == 19), (c <= 19)}) begin
        n_fail++;
        $display("FAIL load4_done C%0d: done/busy %b%b required %b%b", c, fetch_done, busy, (c == 19), (c <= 19));
      end
    end
    n_checks++;
    if (datain !== {32'h2F, 32'h2B, 32'h27, 32'h23}) begin
      n_fail++;
      $display("FAIL load4_hold: got %h required %h", datain, {32'h2F, 32'h2B, 32'h27, 32'h23});
    end
  endtask

  task automatic test_load_single;
    cfg(4'd0, 2'd0, 2'd1, 1'b0, 1'b0);
    start(1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_rd_en, mem_rd_addr} !== {(c == 1), (c == 1) ? 8'h04 : 8'h00}) begin
        n_fail++;
        $display("FAIL load1_read C%0d: en %b addr %h required %b 04", c, mem_rd_en, mem_rd_addr, (c == 1));
      end
      n_checks++;
      if (lane_valid !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL load1_valid C%0d: got %b", c, lane_valid);
      end
      n_checks++;
      if ({fetch_done, busy} !== {(c == 4), (c <= 4)}) begin
        n_fail++;
        $display("FAIL load1_done C%0d: done/busy %b%b required %b%b", c, fetch_done, busy, (c == 4), (c <= 4));
      end
    end
    n_checks++;
    if (datain !== {32'h2F, 32'h2B, 32'h04, 32'h23}) begin
      n_fail++;
      $display("FAIL load1_data: got %h required %h", datain, {32'h2F, 32'h2B, 32'h04, 32'h23});
    end
  endtask

  task automatic test_store_half;
    logic [40:0] exp;
    cfg(4'd0, 2'd0, 2'b10, 1'b1, 1'b0);
    dataout = {C_D, C_C, C_B, C_A};
    start(1'b0, 1'b1);
    dataout = '1;  // must not affect the captured values
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp = (c == 1) ? {1'b1, 8'hC0, C_C} : (c == 2) ? {1'b1, 8'hC1, C_D} : 41'h0;
      n_checks++;
      if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== exp) begin
        n_fail++;
        $display("FAIL store_half_wr C%0d: got %h required %h", c, {mem_wr_en, mem_wr_addr, mem_wr_data}, exp);
      end
      n_checks++;
      if ({store_done, busy, mem_rd_en, lane_valid} !== {(c == 3), (c <= 3), 5'b0}) begin
        n_fail++;
        $display("FAIL store_half_done C%0d: done/busy %b%b", c, store_done, busy);
      end
    end
    cfg(4'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    dataout = {C_D, C_C, C_B, C_A};
    start(1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 8'hC2, C_A}) begin
      n_fail++;
      $display("FAIL store_next_wr: got %h required %h", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 8'hC2, C_A});
    end
    @(negedge clk);
    n_checks++;
    if ({store_done, mem_wr_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_next_done: done/wr %b%b required 10", store_done, mem_wr_en);
    end
  endtask

  task automatic test_store_wrap;
    logic [40:0] exp;
    bit seen;
    // Pointer is at 0xC3: 14 four-lane stores plus 3 single stores reach 0xFE.
    for (int s = 0; s < 17; s++) begin
      cfg(4'd0, 2'd0, 2'd0, 1'b0, (s < 14));
      start(1'b0, 1'b1);
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (store_done) seen = 1;
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL wrap_fill_timeout: store %0d STORE_DONE 0 required 1", s);
      end
    end
    cfg(4'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    start(1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      case (c)
        1: exp = {1'b1, 8'hFE, C_A};
        2: exp = {1'b1, 8'hFF, C_B};
        3: exp = {1'b1, 8'hC0, C_C};
        4: exp = {1'b1, 8'hC1, C_D};
        default: exp = 41'h0;
      endcase
      n_checks++;
      if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== exp) begin
        n_fail++;
        $display("FAIL wrap_wr C%0d: got %h required %h", c, {mem_wr_en, mem_wr_addr, mem_wr_data}, exp);
      end
      n_checks++;
      if (store_done !== (c == 5)) begin
        n_fail++;
        $display("FAIL wrap_done C%0d: got %b required %b", c, store_done, (c == 5));
      end
    end
  endtask

  task automatic test_addr_rst;
    cfg(4'd2, 2'd3, 2'd0, 1'b0, 1'b1);
    start(1'b1, 1'b0);
    repeat (5) @(negedge clk);  // now in C5
    addr_rst = 1'b1;
    for (int c = 6; c <= 24; c++) begin
      @(negedge clk);
      n_checks++;
      if ({lane_valid, fetch_done, mem_rd_en, busy} !== 7'h0) begin
        n_fail++;
        $display("FAIL abort_quiet C%0d: valid %b done %b rd %b busy %b required 0", c, lane_valid, fetch_done, mem_rd_en, busy);
      end
      addr_rst = 1'b0;
    end
    cfg(4'd0, 2'd0, 2'd1, 1'b0, 1'b0);
    start(1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 8'hC0, C_B}) begin
      n_fail++;
      $display("FAIL abort_ptr: got %h required %h", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 8'hC0, C_B});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_collision;
    cfg(4'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    start(1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_wr_en, store_done, fetch_done} !== {2'b00, (c == 4)}) begin
        n_fail++;
        $display("FAIL both_start C%0d: wr %b sdone %b fdone %b required 00%b", c, mem_wr_en, store_done, fetch_done, (c == 4));
      end
      if (c == 1) begin
        n_checks++;
        if ({mem_rd_en, mem_rd_addr} !== {1'b1, 8'h10}) begin
          n_fail++;
          $display("FAIL both_read: got %b %h required 1 10", mem_rd_en, mem_rd_addr);
        end
      end
`ifdef DATA_FETCH_ERR_EN
      n_checks++;
      if (start_err !== (c == 1)) begin
        n_fail++;
        $display("FAIL both_err C%0d: got %b required %b", c, start_err, (c == 1));
      end
`endif
    end
    // Starts and new config while busy must be ignored.
    cfg(4'd2, 2'd3, 2'd0, 1'b0, 1'b1);
    start(1'b1, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_rd_en, mem_rd_addr, mem_wr_en, store_done, fetch_done} !==
          {(c <= 16), (c <= 16) ? 8'(8'h20 + c - 1) : 8'h00, 2'b00, (c == 19)}) begin
        n_fail++;
        $display("FAIL busy_start C%0d: rd %b %h wr %b sdone %b fdone %b", c, mem_rd_en, mem_rd_addr, mem_wr_en, store_done, fetch_done);
      end
`ifdef DATA_FETCH_ERR_EN
      n_checks++;
      if (start_err !== (c == 3)) begin
        n_fail++;
        $display("FAIL busy_err C%0d: got %b required %b", c, start_err, (c == 3));
      end
`endif
      if (c == 2) begin
        addr_start = 1'b1; wraddr_start = 1'b1; address = 4'd5;
      end else begin
        addr_start = 1'b0; wraddr_start = 1'b0;
      end
    end
  endtask

  task automatic test_rst_midop;
    cfg(4'd2, 2'd3, 2'd0, 1'b0, 1'b1);
    start(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, lane_valid, mem_rd_en, datain} !== '0) begin
      n_fail++;
      $display("FAIL rst_midop: busy %b valid %b rd %b datain %h required 0", busy, lane_valid, mem_rd_en, datain);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy, lane_valid, fetch_done} !== '0) begin
      n_fail++;
      $display("FAIL rst_midop_quiet: busy %b valid %b done %b required 0", busy, lane_valid, fetch_done);
    end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_load_single();
    test_store_half();
    test_store_wrap();
    test_addr_rst();
    test_collision();
    test_rst_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
